jump_redirect_unit: RTL and testbench

- Parametrised successor to the single-instruction JR decoder for the pipelined MIPS datapath.
- Decodes J, JAL, JR and JALR in ID and produces a registered PC redirect, the IF/ID flush and the link-register write.
- Stalls register jumps until the forwarded rs value is ready.
- Keeps a return-address stack (RAS) that checks JR $ra targets.
- Sits between ID decode/forwarding and the PC mux / register file write port.

---
 rtl/jump_redirect_unit.sv | 204 ++++++++++++++++++++
 tb/tb_jump_redirect_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_redirect_unit.sv
// jump_redirect_unit: decodes J/JAL/JR/JALR in ID and produces a registered PC
// redirect, a timed IF/ID flush and the link-register write. Register jumps wait
// for the forwarded rs value. A small return-address stack checks JR $ra targets.
module jump_redirect_unit #(
  parameter int WIDTH        = 32,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int RA_REG       = 31
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             id_valid,
  input  logic [5:0]                       opcode,
  input  logic [5:0]                       funct,
  input  logic [1:0]                       aluop,
  input  logic [4:0]                       rs_addr,
  input  logic [4:0]                       rd_addr,
  input  logic [WIDTH-1:0]                 rs_data,
  input  logic                             rs_ready,
  input  logic [WIDTH-1:0]                 pc_plus4,
  input  logic [25:0]                      jtarget,
  output logic                             stall,
  output logic                             redirect,
  output logic [WIDTH-1:0]                 redirect_pc,
  output logic                             flush,
  output logic                             link_we,
  output logic [4:0]                       link_addr,
  output logic [WIDTH-1:0]                 link_data,
  output logic                             ras_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RS, FLUSH} state_t;

  state_t            state, next_state;
  logic [1:0]        flush_cnt;

  // Fields captured when a register jump has to wait for its rs operand.
  logic              lat_jalr;
  logic [4:0]        lat_rs, lat_rd;
  logic [WIDTH-1:0]  lat_pc;

  logic [WIDTH-1:0]  ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ras_ptr, ptr_inc, ptr_dec, ptr_n, ras_widx;
  logic [CW-1:0]     cnt_n;
  logic              ras_we;

  logic              dec_j, dec_jal, dec_jr, dec_jalr;
  logic              accept, stall_req;
  logic              c_jal, c_jalr, c_reg;
  logic [4:0]        c_rs, c_rd;
  logic [WIDTH-1:0]  c_pc, target;
  logic              do_link, push, pop, hit;

  // Instruction decode of the live ID-stage fields.
  always_comb begin
    dec_j    = (opcode == 6'b000010);
    dec_jal  = (opcode == 6'b000011);
    dec_jr   = (aluop == 2'b10) && (funct == 6'b001000);
    dec_jalr = (aluop == 2'b10) && (funct == 6'b001001);
  end

  // Next-state logic; also selects live or latched jump fields for the accept.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    stall_req  = 1'b0;
    c_jal      = 1'b0;
    c_jalr     = 1'b0;
    c_reg      = 1'b0;
    c_rs       = rs_addr;
    c_rd       = rd_addr;
    c_pc       = pc_plus4;
    case (state)
      IDLE: begin
        if (id_valid) begin
          if (dec_j || dec_jal) begin
            accept = 1'b1;
            c_jal  = dec_jal;
          end else if (dec_jr || dec_jalr) begin
            c_reg  = 1'b1;
            c_jalr = dec_jalr;
            if (rs_ready) begin
              accept = 1'b1;
            end else begin
              stall_req  = 1'b1;
              next_state = WAIT_RS;
            end
          end
        end
      end
      WAIT_RS: begin
        c_reg  = 1'b1;
        c_jalr = lat_jalr;
        c_rs   = lat_rs;
        c_rd   = lat_rd;
        c_pc   = lat_pc;
        if (rs_ready) accept = 1'b1;
        else          stall_req = 1'b1;
      end
      FLUSH: begin
        if (flush_cnt == 2'd0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (accept) next_state = FLUSH;
  end

  // Target, link and return-address-stack decisions for the accepted jump.
  always_comb begin
    target   = c_reg ? rs_data : {c_pc[WIDTH-1:28], jtarget, 2'b00};
    do_link  = c_jal || (c_jalr && (c_rd != 5'd0));
    push     = accept && do_link;
    pop      = accept && c_reg && (c_rs == 5'(RA_REG));
    ptr_inc  = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PW'(1);
    ptr_dec  = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - PW'(1);
    hit      = pop && (ras_count != '0) && (ras_mem[ptr_dec] == rs_data);
    ras_we   = 1'b0;
    ras_widx = ras_ptr;
    ptr_n    = ras_ptr;
    cnt_n    = ras_count;
    if (push && pop && (ras_count != '0)) begin
      ras_we   = 1'b1;
      ras_widx = ptr_dec;
    end else if (push) begin
      ras_we = 1'b1;
      ptr_n  = ptr_inc;
      if (ras_count != CW'(RAS_DEPTH)) cnt_n = ras_count + CW'(1);
    end else if (pop && (ras_count != '0)) begin
      ptr_n = ptr_dec;
      cnt_n = ras_count - CW'(1);
    end
  end

  // Stall is never asserted while the unit is held in reset.
  assign stall = rst_n && stall_req;

  // State, flush timer and registered redirect/link outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_cnt   <= 2'd0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      link_we     <= 1'b0;
      link_addr   <= 5'd0;
      link_data   <= '0;
      ras_hit     <= 1'b0;
    end else begin
      state    <= next_state;
      redirect <= accept;
      link_we  <= push;
      ras_hit  <= hit;
      if (accept) begin
        redirect_pc <= target;
        flush       <= 1'b1;
        flush_cnt   <= 2'(FLUSH_CYCLES - 1);
        if (c_jal || c_jalr) begin
          link_addr <= c_jal ? 5'(RA_REG) : c_rd;
          link_data <= c_pc;
        end
      end else if (state == FLUSH) begin
        if (flush_cnt == 2'd0) flush     <= 1'b0;
        else                   flush_cnt <= flush_cnt - 2'd1;
      end
    end
  end

  // Capture the waiting register jump so ID may change underneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_jalr <= 1'b0;
      lat_rs   <= 5'd0;
      lat_rd   <= 5'd0;
      lat_pc   <= '0;
    end else if (state == IDLE && next_state == WAIT_RS) begin
      lat_jalr <= dec_jalr;
      lat_rs   <= rs_addr;
      lat_rd   <= rd_addr;
      lat_pc   <= pc_plus4;
    end
  end

  // Return-address stack pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else begin
      ras_ptr   <= ptr_n;
      ras_count <= cnt_n;
    end
  end

  // Return-address stack storage (contents are qualified by ras_count).
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_widx] <= c_pc;
  end

endmodule

// File: tb/tb_jump_redirect_unit.sv
// tb_jump_redirect_unit: directed vector table plus hand sequences for the RAS,
// the long flush window and asynchronous reset. dut uses FLUSH_CYCLES=1,
// dut3 uses FLUSH_CYCLES=3; both see the same inputs.
module tb_jump_redirect_unit;

  localparam int K_NOP = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_JALR = 4, K_ADD = 5;

  logic        clk, rst_n, id_valid, rs_ready;
  logic [5:0]  opcode, funct;
  logic [1:0]  aluop;
  logic [4:0]  rs_addr, rd_addr;
  logic [31:0] rs_data, pc_plus4;
  logic [25:0] jtarget;

  logic        stall, redirect, flush, link_we, ras_hit;
  logic [31:0] redirect_pc, link_data;
  logic [4:0]  link_addr;
  logic [2:0]  ras_count;

  logic        stall3, redirect3, flush3, link_we3, ras_hit3;
  logic [31:0] redirect_pc3, link_data3;
  logic [4:0]  link_addr3;
  logic [2:0]  ras_count3;

  int checks = 0;
  int failures = 0;

  jump_redirect_unit #(.WIDTH(32), .RAS_DEPTH(4), .FLUSH_CYCLES(1), .RA_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .aluop(aluop), .rs_addr(rs_addr), .rd_addr(rd_addr), .rs_data(rs_data),
    .rs_ready(rs_ready), .pc_plus4(pc_plus4), .jtarget(jtarget), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .link_we(link_we),
    .link_addr(link_addr), .link_data(link_data), .ras_hit(ras_hit), .ras_count(ras_count)
  );

  jump_redirect_unit #(.WIDTH(32), .RAS_DEPTH(4), .FLUSH_CYCLES(3), .RA_REG(31)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .aluop(aluop), .rs_addr(rs_addr), .rd_addr(rd_addr), .rs_data(rs_data),
    .rs_ready(rs_ready), .pc_plus4(pc_plus4), .jtarget(jtarget), .stall(stall3),
    .redirect(redirect3), .redirect_pc(redirect_pc3), .flush(flush3), .link_we(link_we3),
    .link_addr(link_addr3), .link_data(link_data3), .ras_hit(ras_hit3), .ras_count(ras_count3)
  );

  typedef struct {
    int          kind;
    logic [4:0]  rs, rd;
    logic [31:0] data;
    logic        ready;
    logic [31:0] pc;
    logic [25:0] jt;
    logic        e_stall, e_redir;
    logic [31:0] e_rpc;
    logic        e_flush, e_lwe;
    logic [4:0]  e_la;
    logic [31:0] e_ld;
    logic        e_hit;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [17];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(int kind, logic [4:0] rs, logic [4:0] rd, logic [31:0] data,
                              logic ready, logic [31:0] pc, logic [25:0] jt,
                              logic e_stall, logic e_redir, logic [31:0] e_rpc,
                              logic e_flush, logic e_lwe, logic [4:0] e_la,
                              logic [31:0] e_ld, logic e_hit, logic [2:0] e_cnt);
    vec_t v;
    v.kind = kind; v.rs = rs; v.rd = rd; v.data = data; v.ready = ready; v.pc = pc;
    v.jt = jt; v.e_stall = e_stall; v.e_redir = e_redir; v.e_rpc = e_rpc;
    v.e_flush = e_flush; v.e_lwe = e_lwe; v.e_la = e_la; v.e_ld = e_ld;
    v.e_hit = e_hit; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic applyStimulus(int kind, logic [4:0] rs, logic [4:0] rd, logic [31:0] data,
                               logic ready, logic [31:0] pc, logic [25:0] jt);
    id_valid = (kind != K_NOP);
    opcode   = 6'b000000;
    funct    = 6'b000000;
    aluop    = 2'b00;
    case (kind)
      K_J:    begin opcode = 6'b000010; funct = jt[5:0]; end
      K_JAL:  begin opcode = 6'b000011; funct = jt[5:0]; end
      K_JR:   begin aluop = 2'b10; funct = 6'b001000; end
      K_JALR: begin aluop = 2'b10; funct = 6'b001001; end
      K_ADD:  begin aluop = 2'b10; funct = 6'b100000; end
      default: ;
    endcase
    rs_addr  = rs;
    rd_addr  = rd;
    rs_data  = data;
    rs_ready = ready;
    pc_plus4 = pc;
    jtarget  = jt;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    applyStimulus(K_NOP, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 26'h0);
  endtask

  initial begin
    // Table: one row per cycle; stall checked mid-cycle, registered outputs after the edge.
    vecs[0]  = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0,        0,0, 0,32'h0,        0,0);
    vecs[1]  = mk(K_J,    0, 0, 32'h0,         0, 32'h0040_0010, 26'h010_0004,0,1,32'h0040_0010,1,0, 0,32'h0,        0,0);
    vecs[2]  = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0040_0010,0,0, 0,32'h0,        0,0);
    vecs[3]  = mk(K_JAL,  0, 0, 32'h0,         0, 32'h0040_0020, 26'h010_0100,0,1,32'h0040_0400,1,1,31,32'h0040_0020,0,1);
    vecs[4]  = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0040_0400,0,0,31,32'h0040_0020,0,1);
    vecs[5]  = mk(K_JR,  31, 0, 32'h0040_0020, 1, 32'h0040_0404, 26'h0,       0,1,32'h0040_0020,1,0,31,32'h0040_0020,1,0);
    vecs[6]  = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0040_0020,0,0,31,32'h0040_0020,0,0);
    vecs[7]  = mk(K_JR,   8, 0, 32'hDEAD_BEEF, 0, 32'h0040_0030, 26'h0,       1,0,32'h0040_0020,0,0,31,32'h0040_0020,0,0);
    vecs[8]  = mk(K_JR,   8, 0, 32'hDEAD_BEEF, 0, 32'h0040_0030, 26'h0,       1,0,32'h0040_0020,0,0,31,32'h0040_0020,0,0);
    vecs[9]  = mk(K_JR,   8, 0, 32'hDEAD_BEEF, 0, 32'h0040_0030, 26'h0,       1,0,32'h0040_0020,0,0,31,32'h0040_0020,0,0);
    vecs[10] = mk(K_JR,   8, 0, 32'h1000_0000, 1, 32'h0040_0030, 26'h0,       0,1,32'h1000_0000,1,0,31,32'h0040_0020,0,0);
    vecs[11] = mk(K_J,    0, 0, 32'h0,         0, 32'h0040_0010, 26'h000_0001,0,0,32'h1000_0000,0,0,31,32'h0040_0020,0,0);
    vecs[12] = mk(K_J,    0, 0, 32'h0,         0, 32'h0040_0050, 26'h010_0040,0,1,32'h0040_0100,1,0,31,32'h0040_0020,0,0);
    vecs[13] = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0040_0100,0,0,31,32'h0040_0020,0,0);
    vecs[14] = mk(K_ADD,  8, 9, 32'h1234_5678, 1, 32'h0040_0054, 26'h0,       0,0,32'h0040_0100,0,0,31,32'h0040_0020,0,0);
    vecs[15] = mk(K_JALR, 8, 5, 32'h0040_0200, 1, 32'h0040_0060, 26'h0,       0,1,32'h0040_0200,1,1, 5,32'h0040_0060,0,1);
    vecs[16] = mk(K_NOP,  0, 0, 32'h0,         0, 32'h0,         26'h0,       0,0,32'h0040_0200,0,0, 5,32'h0040_0060,0,1);

    // Reset state, with a not-ready JR presented to show stall is gated.
    rst_n = 1'b0;
    applyStimulus(K_JR, 5'd8, 5'd0, 32'h0, 1'b0, 32'h0040_0000, 26'h0);
    #2;
    checkOutput("reset stall", stall, 0);
    checkOutput("reset redirect", redirect, 0);
    checkOutput("reset redirect_pc", redirect_pc, 0);
    checkOutput("reset flush", flush, 0);
    checkOutput("reset link_we", link_we, 0);
    checkOutput("reset ras_count", ras_count, 0);
    @(posedge clk);
    #1;
    nop();
    rst_n = 1'b1;
    tick();

    // Directed vector table against the FLUSH_CYCLES=1 instance.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].rs, vecs[i].rd, vecs[i].data, vecs[i].ready,
                    vecs[i].pc, vecs[i].jt);
      @(negedge clk);
      checkOutput($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
      tick();
      checkOutput($sformatf("v%0d redirect", i), redirect, vecs[i].e_redir);
      checkOutput($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      checkOutput($sformatf("v%0d flush", i), flush, vecs[i].e_flush);
      checkOutput($sformatf("v%0d link_we", i), link_we, vecs[i].e_lwe);
      checkOutput($sformatf("v%0d link_addr", i), link_addr, vecs[i].e_la);
      checkOutput($sformatf("v%0d link_data", i), link_data, vecs[i].e_ld);
      checkOutput($sformatf("v%0d ras_hit", i), ras_hit, vecs[i].e_hit);
      checkOutput($sformatf("v%0d ras_count", i), ras_count, vecs[i].e_cnt);
    end

    // RAS overflow: five calls into a four-deep stack, then five returns.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(K_JAL, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_1000 + 32'(i * 16), 26'h0);
      tick();
      checkOutput($sformatf("ras push%0d link_we", i), link_we, 1);
      checkOutput($sformatf("ras push%0d count", i), ras_count, (i < 4) ? i + 1 : 4);
      nop();
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(K_JR, 5'd31, 5'd0, 32'h0040_1000 + 32'((4 - i) * 16), 1'b1, 32'h0040_1800, 26'h0);
      tick();
      checkOutput($sformatf("ras pop%0d redirect", i), redirect, 1);
      checkOutput($sformatf("ras pop%0d hit", i), ras_hit, (i < 4) ? 1 : 0);
      checkOutput($sformatf("ras pop%0d count", i), ras_count, (i < 4) ? 3 - i : 0);
      nop();
      tick();
    end

    // Simultaneous pop and push replaces the top entry.
    applyStimulus(K_JAL, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_2000, 26'h0);
    tick();
    nop();
    tick();
    applyStimulus(K_JALR, 5'd31, 5'd31, 32'h0040_2000, 1'b1, 32'h0040_2100, 26'h0);
    tick();
    checkOutput("swap hit", ras_hit, 1);
    checkOutput("swap count", ras_count, 1);
    checkOutput("swap link_addr", link_addr, 31);
    nop();
    tick();
    applyStimulus(K_JR, 5'd31, 5'd0, 32'h0040_2100, 1'b1, 32'h0040_2200, 26'h0);
    tick();
    checkOutput("swap pop hit", ras_hit, 1);
    checkOutput("swap pop count", ras_count, 0);
    nop();
    tick();

    // Three-cycle flush on dut3: JALR rd=0 via $ra pops without linking.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(K_JAL, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_3000, 26'h0);
    tick();
    checkOutput("f3 jal count", ras_count3, 1);
    nop();
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(K_JALR, 5'd31, 5'd0, 32'h0040_3000, 1'b1, 32'h0040_3104, 26'h0);
    tick();
    checkOutput("f3 jalr redirect", redirect3, 1);
    checkOutput("f3 jalr redirect_pc", redirect_pc3, 32'h0040_3000);
    checkOutput("f3 jalr link_we", link_we3, 0);
    checkOutput("f3 jalr hit", ras_hit3, 1);
    checkOutput("f3 jalr count", ras_count3, 0);
    checkOutput("f3 flush0", flush3, 1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(K_J, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_0010, 26'h010_0004);
      tick();
      checkOutput($sformatf("f3 ignored J%0d redirect", i), redirect3, 0);
      checkOutput($sformatf("f3 flush%0d", i), flush3, (i < 3) ? 1 : 0);
    end
    nop();
    tick();

    // Reset during WAIT_RS abandons the jump and zeroes the outputs.
    applyStimulus(K_JR, 5'd8, 5'd0, 32'h0, 1'b0, 32'h0040_4000, 26'h0);
    tick();
    checkOutput("wait stall", stall, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst wait stall", stall, 0);
    checkOutput("rst wait redirect_pc", redirect_pc, 0);
    checkOutput("rst wait link_addr", link_addr, 0);
    checkOutput("rst wait link_data", link_data, 0);
    checkOutput("rst wait count", ras_count, 0);
    @(posedge clk);
    #1;
    nop();
    rst_n = 1'b1;
    tick();
    checkOutput("post rst redirect", redirect, 0);
    applyStimulus(K_J, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_0010, 26'h010_0004);
    tick();
    checkOutput("post rst J redirect", redirect, 1);
    checkOutput("post rst J redirect_pc", redirect_pc, 32'h0040_0010);

    // Reset during FLUSH on dut3 drops flush immediately.
    nop();
    tick();
    checkOutput("pre rst flush3", flush3, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst flush3", flush3, 0);
    checkOutput("rst redirect_pc3", redirect_pc3, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post rst flush3", flush3, 0);
    checkOutput("post rst redirect3", redirect3, 0);
    applyStimulus(K_J, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0040_0050, 26'h010_0040);
    tick();
    checkOutput("post rst J3 redirect", redirect3, 1);
    checkOutput("post rst J3 redirect_pc", redirect_pc3, 32'h0040_0100);
    checkOutput("post rst J3 flush", flush3, 1);
    nop();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
